// File: rtl/text_vmem_pkg.sv
// Shared constants, FSM states and line-mapping helper for the text-mode video memory.
package text_vmem_pkg;

  localparam logic [7:0] KEY_NL   = 8'h0A;
  localparam logic [7:0] KEY_BS   = 8'h08;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CLEAR_ROW
  } state_e;

  // Logical text line to physical storage line under a circular top-row base.
  function automatic int unsigned log2phys(input int unsigned top, input int unsigned y,
                                           input int unsigned rows);
    return (top + y >= rows) ? (top + y - rows) : (top + y);
  endfunction

endpackage

// File: rtl/text_pix2cell.sv
// Maps a VGA pixel address to its character cell and glyph coordinates.
module text_pix2cell #(
  parameter int unsigned COLS   = 70,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned CHAR_W = 9,
  parameter int unsigned CHAR_H = 16,
  localparam int unsigned XW    = $clog2(COLS),
  localparam int unsigned YW    = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    h_addr_i,
  input  logic [9:0]    v_addr_i,
  output logic [XW-1:0] cx_c,
  output logic [YW-1:0] cy_c,
  output logic          in_area_c,
  output logic [3:0]    row_o,
  output logic [3:0]    col_o
);

  localparam logic [10:0] H_LIM = 11'(COLS * CHAR_W);
  localparam logic [10:0] V_LIM = 11'(ROWS * CHAR_H);

  // Cell indices are only meaningful inside the text area; truncation is safe there.
  assign cx_c      = XW'(h_addr_i / 10'(CHAR_W));
  assign cy_c      = YW'(v_addr_i / 10'(CHAR_H));
  assign in_area_c = ({1'b0, h_addr_i} < H_LIM) && ({1'b0, v_addr_i} < V_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      row_o <= '0;
      col_o <= '0;
    end else begin
      row_o <= 4'(v_addr_i % 10'(CHAR_H));
      col_o <= 4'(h_addr_i % 10'(CHAR_W));
    end
  end

endmodule

// File: rtl/text_vmem.sv
// Text-mode video memory: keyboard-driven cursor writes, scrolling, and VGA read port.
module text_vmem
  import text_vmem_pkg::*;
#(
  parameter int unsigned COLS   = 70,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned CHAR_W = 9,
  parameter int unsigned CHAR_H = 16,
  localparam int unsigned AW    = $clog2(COLS * ROWS),
  localparam int unsigned XW    = $clog2(COLS),
  localparam int unsigned YW    = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    key_in,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [9:0]    h_addr,
  input  logic [9:0]    v_addr,
  output logic [7:0]    ascii_out,
  output logic [3:0]    row,
  output logic [3:0]    col,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          busy
);

  localparam int unsigned CELLS = COLS * ROWS;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [YW-1:0] top_q, top_d;
  logic          ready_q;
  logic [7:0]    ascii_q;

  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [7:0]    wdata_c;
  logic          do_nl_c;
  logic          printable_c;

  logic [XW-1:0] rd_cx_c;
  logic [YW-1:0] rd_cy_c;
  logic          rd_in_area_c;
  logic [AW-1:0] raddr_c;

  logic [7:0]    mem [CELLS];

  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] top, input logic [YW-1:0] y,
                                              input logic [XW-1:0] x);
    return AW'(log2phys(32'(top), 32'(y), ROWS) * COLS + 32'(x));
  endfunction

  assign printable_c = (key_in >= PRINT_LO) && (key_in <= PRINT_HI);

  // Next-state: sweeps for INIT/CLEAR_ROW, key interpretation in IDLE.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    top_d   = top_q;
    we_c    = 1'b0;
    waddr_c = '0;
    wdata_c = '0;
    do_nl_c = 1'b0;
    case (state_q)
      INIT: begin
        we_c    = 1'b1;
        waddr_c = clr_q;
        if (clr_q == AW'(CELLS - 1)) begin
          state_d = IDLE;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + AW'(1);
        end
      end
      IDLE: begin
        if (key_valid && ready_q) begin
          if (printable_c) begin
            we_c    = 1'b1;
            waddr_c = cell_addr(top_q, cy_q, cx_q);
            wdata_c = key_in;
            if (cx_q < XW'(COLS - 1)) cx_d = cx_q + XW'(1);
            else                      do_nl_c = 1'b1;
          end else if (key_in == KEY_NL) begin
            do_nl_c = 1'b1;
          end else if (key_in == KEY_BS) begin
            if (cx_q != '0) begin
              cx_d    = cx_q - XW'(1);
              we_c    = 1'b1;
              waddr_c = cell_addr(top_q, cy_q, cx_q - XW'(1));
            end else if (cy_q != '0) begin
              cx_d    = XW'(COLS - 1);
              cy_d    = cy_q - YW'(1);
              we_c    = 1'b1;
              waddr_c = cell_addr(top_q, cy_q - YW'(1), XW'(COLS - 1));
            end
          end
        end
        // Scrolling advances the base; the vacated line becomes the new bottom line.
        if (do_nl_c) begin
          cx_d = '0;
          if (cy_q < YW'(ROWS - 1)) begin
            cy_d = cy_q + YW'(1);
          end else begin
            top_d   = (top_q == YW'(ROWS - 1)) ? '0 : top_q + YW'(1);
            state_d = CLEAR_ROW;
            clr_d   = '0;
          end
        end
      end
      CLEAR_ROW: begin
        we_c    = 1'b1;
        waddr_c = cell_addr(top_q, YW'(ROWS - 1), XW'(clr_q));
        if (clr_q == AW'(COLS - 1)) begin
          state_d = IDLE;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + AW'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      clr_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      top_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      top_q   <= top_d;
      ready_q <= (state_d == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (we_c) mem[waddr_c] <= wdata_c;
  end

  text_pix2cell #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .CHAR_W (CHAR_W),
    .CHAR_H (CHAR_H)
  ) u_pix2cell (
    .clk       (clk),
    .reset     (reset),
    .h_addr_i  (h_addr),
    .v_addr_i  (v_addr),
    .cx_c      (rd_cx_c),
    .cy_c      (rd_cy_c),
    .in_area_c (rd_in_area_c),
    .row_o     (row),
    .col_o     (col)
  );

  assign raddr_c = rd_in_area_c ? cell_addr(top_q, rd_cy_c, rd_cx_c) : '0;

  // Registered read; a same-edge write lands after this sample, so old data is returned.
  always_ff @(posedge clk) begin
    if (reset)             ascii_q <= '0;
    else if (rd_in_area_c) ascii_q <= mem[raddr_c];
    else                   ascii_q <= '0;
  end

  assign ascii_out = ascii_q;
  assign key_ready = ready_q;
  assign busy      = ~ready_q;
  assign cursor_x  = cx_q;
  assign cursor_y  = cy_q;

endmodule

// File: tb/tb_text_vmem.sv
// Self-checking bench for text_vmem against a logical-screen reference model.
module tb_text_vmem;

  localparam int COLS = 70;
  localparam int ROWS = 30;
  localparam int CW   = 9;
  localparam int CH   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [9:0] h_addr;
  logic [9:0] v_addr;
  logic [7:0] ascii_out;
  logic [3:0] row;
  logic [3:0] col;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference: the screen as the user sees it (logical lines), plus cursor.
  logic [7:0] scr [ROWS][COLS];
  int mx, my;

  text_vmem dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .h_addr    (h_addr),
    .v_addr    (v_addr),
    .ascii_out (ascii_out),
    .row       (row),
    .col       (col),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    mx = 0;
    my = 0;
  endtask

  task automatic model_nl();
    mx = 0;
    if (my < ROWS - 1) begin
      my++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
    end
  endtask

  task automatic model_key(input logic [7:0] k);
    if (k >= 8'h20 && k <= 8'h7E) begin
      scr[my][mx] = k;
      if (mx < COLS - 1) mx++;
      else model_nl();
    end else if (k == 8'h0A) begin
      model_nl();
    end else if (k == 8'h08) begin
      if (mx > 0) begin
        mx--;
        scr[my][mx] = 8'h00;
      end else if (my > 0) begin
        my--;
        mx = COLS - 1;
        scr[my][mx] = 8'h00;
      end
    end
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (!key_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: key_ready still %0b after %0d cycles", key_ready, n);
    end
  endtask

  task automatic send_key(input logic [7:0] k);
    int n;
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    wait_ready(5000, n);
    @(negedge clk);
    key_valid = 1'b0;
    model_key(k);
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    key_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    wait_ready(3000, n);
  endtask

  task automatic check_cursor(input string name);
    checks += 2;
    if (cursor_x !== 7'(mx)) begin
      errors++;
      $display("FAIL %s cursor_x: got %0d expected %0d", name, cursor_x, mx);
    end
    if (cursor_y !== 5'(my)) begin
      errors++;
      $display("FAIL %s cursor_y: got %0d expected %0d", name, cursor_y, my);
    end
  endtask

  task automatic check_pix(input int h, input int v, input string name);
    logic [7:0] ea;
    logic [3:0] er, ec;
    @(negedge clk);
    h_addr = 10'(h);
    v_addr = 10'(v);
    @(negedge clk);
    ea = (h < COLS * CW && v < ROWS * CH) ? scr[v / CH][h / CW] : 8'h00;
    er = 4'(v % CH);
    ec = 4'(h % CW);
    checks += 3;
    if (ascii_out !== ea) begin
      errors++;
      $display("FAIL %s ascii h=%0d v=%0d: got %02h expected %02h", name, h, v, ascii_out, ea);
    end
    if (row !== er) begin
      errors++;
      $display("FAIL %s row h=%0d v=%0d: got %0d expected %0d", name, h, v, row, er);
    end
    if (col !== ec) begin
      errors++;
      $display("FAIL %s col h=%0d v=%0d: got %0d expected %0d", name, h, v, col, ec);
    end
  endtask

  task automatic check_screen(input string name);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        check_pix(x * CW + int'($urandom_range(0, CW - 1)),
                  y * CH + int'($urandom_range(0, CH - 1)), name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (key_ready !== 1'b0) begin errors++; $display("FAIL reset key_ready: got %0b expected 0", key_ready); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL reset busy: got %0b expected 1", busy); end
    if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      errors++;
      $display("FAIL reset cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y);
    end
    if (ascii_out !== 8'h00) begin errors++; $display("FAIL reset ascii_out: got %02h expected 00", ascii_out); end
    if (row !== 4'd0) begin errors++; $display("FAIL reset row: got %0d expected 0", row); end
    if (col !== 4'd0) begin errors++; $display("FAIL reset col: got %0d expected 0", col); end
    // Abort an INIT sweep part-way; the next test times the full restart.
    reset = 1'b0;
    repeat (500) @(negedge clk);
    checks++;
    if (key_ready !== 1'b0) begin errors++; $display("FAIL mid_init key_ready: got %0b expected 0", key_ready); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init_accept();
    int n = 0;
    model_clear();
    key_in    = 8'h41;
    key_valid = 1'b1;
    reset     = 1'b0;
    while (!key_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 2100) begin errors++; $display("FAIL init_latency: got %0d cycles expected 2100", n); end
    @(negedge clk);
    key_valid = 1'b0;
    model_key(8'h41);
    check_cursor("init_accept");
    check_pix(0, 0, "init_accept_pix");
  endtask

  task automatic test_line_wrap();
    do_reset();
    repeat (70) send_key(8'h78);
    check_cursor("line_wrap");
    check_pix(629, 0, "wrap_last_col");
    check_pix(630, 0, "wrap_past_edge");
    check_pix(0, 16, "wrap_next_line");
  endtask

  task automatic test_backspace();
    do_reset();
    send_key(8'h61);
    send_key(8'h62);
    repeat (3) send_key(8'h08);
    check_cursor("bs_home");
    check_pix(0, 0, "bs_cell0");
    check_pix(9, 0, "bs_cell1");
    repeat (70) send_key(8'h71);
    send_key(8'h08);
    check_cursor("bs_wrap_up");
    check_pix(69 * CW, 0, "bs_wrap_cleared");
    check_pix(68 * CW + 4, 0, "bs_wrap_kept");
  endtask

  task automatic test_scroll();
    int n = 0;
    do_reset();
    for (int y = 0; y < ROWS - 1; y++) begin
      int cnt = int'($urandom_range(1, 12));
      for (int i = 0; i < cnt; i++) send_key(8'($urandom_range(8'h21, 8'h7E)));
      send_key(8'h0A);
    end
    repeat (5) send_key(8'($urandom_range(8'h21, 8'h7E)));
    check_cursor("scroll_pre");
    // Newline at the bottom line, then 'Z' held during the clear sweep.
    @(negedge clk);
    key_in    = 8'h0A;
    key_valid = 1'b1;
    @(negedge clk);
    model_key(8'h0A);
    key_in = 8'h5A;
    while (!key_ready && n < 200) begin
      if (n == 35) begin
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd29) begin
          errors++;
          $display("FAIL scroll_hold cursor: got (%0d,%0d) expected (0,29)", cursor_x, cursor_y);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 70) begin errors++; $display("FAIL clear_row_busy: got %0d cycles expected 70", n); end
    @(negedge clk);
    key_valid = 1'b0;
    model_key(8'h5A);
    check_cursor("scroll_z");
    check_screen("scroll_screen");
    send_key(8'h1B);
    check_cursor("esc_ignored");
    check_pix(CW, 29 * CH, "esc_no_write");
    check_pix(0, 29 * CH, "z_cell");
  endtask

  task automatic test_random();
    logic [7:0] k;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 60)      k = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 75) k = 8'h0A;
      else if (r < 90) k = 8'h08;
      else begin
        k = 8'($urandom_range(0, 255));
        while ((k >= 8'h20 && k <= 8'h7E) || k == 8'h0A || k == 8'h08) k = 8'($urandom_range(0, 255));
      end
      send_key(k);
      if (i % 50 == 49) check_cursor("random_cursor");
    end
    begin
      int n;
      wait_ready(200, n);
    end
    check_screen("random_screen");
  endtask

  task automatic test_pixels();
    for (int i = 0; i < 300; i++)
      check_pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), "random_pix");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    while (my < ROWS - 1) send_key(8'h0A);
    send_key(8'h51);
    @(negedge clk);
    key_in    = 8'h0A;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (key_ready !== 1'b0) begin errors++; $display("FAIL mid_clear busy: key_ready got %0b expected 0", key_ready); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    wait_ready(3000, n);
    checks++;
    if (n !== 2100) begin errors++; $display("FAIL reinit_latency: got %0d cycles expected 2100", n); end
    check_cursor("reinit_cursor");
    check_screen("reinit_screen");
    send_key(8'h51);
    send_key(8'h0A);
    send_key(8'h52);
    check_cursor("reinit_type");
    check_pix(0, 0, "reinit_q");
    check_pix(0, CH, "reinit_r");
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_in    = 8'h00;
    h_addr    = 10'd0;
    v_addr    = 10'd0;
    test_reset();
    test_init_accept();
    test_line_wrap();
    test_backspace();
    test_scroll();
    test_random();
    test_pixels();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_vmem.md
Name: text_vmem

Overview:
Parametrised text-mode video memory between the PS/2 key decoder and the VGA character generator. Accepts ASCII codes through a valid/ready handshake and stores them at a hardware cursor. Supports newline, backspace, line wrap and hardware scrolling through a circular row base. For each VGA pixel address, returns the character code plus the glyph row and glyph column for the font ROM.

Parameters:
COLS, 70, characters per text line
ROWS, 30, text lines on screen
CHAR_W, 9, glyph width in pixels
CHAR_H, 16, glyph height in pixels (at most 16)
AW, $clog2(COLS*ROWS), cell address width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
key_in  in  8  ASCII code from keyboard path
key_valid  in  1  key_in valid
key_ready  out  1  block can accept a key this cycle
h_addr  in  10  VGA horizontal pixel address
v_addr  in  10  VGA vertical pixel address
ascii_out  out  8  character at the pixel's cell (registered)
row  out  4  glyph row, v_addr mod CHAR_H (registered)
col  out  4  glyph column, h_addr mod CHAR_W (registered)
cursor_x  out  $clog2(COLS)  current cursor column
cursor_y  out  $clog2(ROWS)  current cursor line (logical)
busy  out  1  INIT or CLEAR_ROW in progress

Behaviour:
- Reset and clocking: clock clk; reset is synchronous and active-high. Reset clears cursor_x, cursor_y, top_row, ascii_out, row and col to 0, and sets state to INIT with clr_cnt=0.
- Storage: COLS*ROWS bytes. Physical line is (top_row + logical_y) mod ROWS. Cell address = phys_line*COLS + x (linear, no bit concatenation).
- State machine:
  - INIT: writes 0 to cell clr_cnt each cycle. After COLS*ROWS cycles → IDLE. key_ready goes high on cycle COLS*ROWS after reset deasserts.
  - IDLE: key_ready=1. A key is accepted when key_valid && key_ready, and is processed in the same clock edge.
  - CLEAR_ROW: writes 0 to COLS cells of the new bottom physical line, one per cycle, then → IDLE. key_ready=0 for exactly COLS cycles.
- busy = ~key_ready. Keys offered while key_ready=0 are not consumed; the sender must hold key_valid.
- Key handling in IDLE:
  - printable (0x20–0x7E): write key_in at the cursor. If cursor_x<COLS-1, increment cursor_x. Otherwise perform a newline.
  - 0x0A (newline): cursor_x←0. If cursor_y<ROWS-1, increment cursor_y. Otherwise keep cursor_y=ROWS-1, set top_row←(top_row+1) mod ROWS and enter CLEAR_ROW. The line to clear is the old top_row physical line.
  - 0x08 (backspace): if cursor_x>0, decrement cursor_x and write 0 at the new position. If cursor_x=0 and cursor_y>0, go to (COLS-1, cursor_y-1) and write 0 there. At (0,0), ignored.
  - all other codes: ignored; no write, no cursor change.
- Display read path, 1-cycle latency:
  - cx=h_addr/CHAR_W, cy=v_addr/CHAR_H; divisors are compile-time constants.
  - row/col are the remainders, truncated to 4 bits.
  - ascii_out = cell at logical (cx, cy).
  - If h_addr ≥ COLS*CHAR_W or v_addr ≥ ROWS*CHAR_H, ascii_out=0 (row/col still valid).
- Write vs read conflict: a same-cycle write and read to one cell returns the old data.
- Reset asserted mid-INIT or mid-CLEAR_ROW aborts the sweep and restarts INIT from cell 0.
- top_row wraps ROWS-1 → 0. cursor_x never exceeds COLS-1; cursor_y never exceeds ROWS-1.

Decomposition:
- Package text_vmem_pkg: ASCII constants KEY_NL=8'h0A, KEY_BS=8'h08, PRINT_LO=8'h20, PRINT_HI=8'h7E; state enum {INIT, IDLE, CLEAR_ROW}; logical→physical line function.
- One sub-module, text_pix2cell: pixel→(cx, cy, row, col, in_area) mapping with the registered output stage. Instantiated once for the read path.

Test Plan:
- Reset, then key_valid held with 'A' (0x41) → key_ready rises after 2100 cycles; cell(0,0)=0x41; cursor=(1,0); pixel (0,0) reads ascii_out=0x41, row=0, col=0 one cycle later.
- 70 × 'x' → cursor=(0,1); pixel h=629,v=0 gives ascii_out=0x78, col=8; pixel h=630 gives ascii_out=0.
- Input "ab", BS, BS, BS → cursor=(0,0); cells (0,0) and (1,0) are 0; third BS ignored.
- 0x0A at cursor_y=29 → top_row=1; key_ready low for exactly 70 cycles; logical line 29 all 0; old logical line 1 now displays at v_addr=0.
- 'Z' (0x5A) offered during CLEAR_ROW → not consumed until key_ready=1, then written at (0,29); 0x1B → no write, cursor unchanged.
- Reset pulsed mid-CLEAR_ROW → INIT restarts; all 2100 cells read 0 afterwards; cursor=(0,0), top_row=0.
